// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operand feeder and the mat_mul bench:
// feeder state encoding and the mat_mul pipeline latency.
package mat_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ISSUE  = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_t;

   // Cycles from mat_mul valid_in to a final result: adder-tree depth plus output register.
   function automatic int mm_latency(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mat_feeder.sv
// Assembles streamed A/B elements into N x N operand pairs for mat_mul and signals job completion.
// Build option MAT_FEEDER_PAD_EN: an early s_last zero-pads and issues the pair instead of flagging err_last.
module mat_feeder
   import mat_pkg::*;
#(
   parameter int W_IN = 8,
   parameter int N    = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic signed [W_IN-1:0]               s_data,
   input  logic                                 s_last,
   output logic                                 mat_valid,
   output logic        [N-1:0][N-1:0][W_IN-1:0] matrix_1,
   output logic        [N-1:0][N-1:0][W_IN-1:0] matrix_2,
   output logic                                 job_done,
   output logic                                 err_last,
   output feeder_state_t                        dbg_state
);

   localparam int NN     = N * N;
   localparam int KW     = $clog2(NN + 1);
   localparam int MM_LAT = mm_latency(N);
   localparam int DW     = $clog2(MM_LAT + 1);

   // Handshake: a beat transfers on a rising edge where s_valid && s_ready;
   // s_valid may rise or fall at will, s_ready is high only in the LOAD states.
   feeder_state_t state, state_nxt;
   logic [KW-1:0] k;
   logic [DW-1:0] dcnt;
   logic          last_pend;
   logic          err_q;
   logic [N-1:0][N-1:0][W_IN-1:0] m1, m2;

   logic load, accept, k_end, final_beat, early_last, drain_end;

   assign load       = (state == LOAD_A) || (state == LOAD_B);
   assign s_ready    = load && !reset;
   assign accept     = s_valid && s_ready;
   assign k_end      = (k == KW'(NN - 1));
   assign final_beat = accept && (state == LOAD_B) && k_end;
   assign early_last = accept && s_last && !final_beat;
   assign drain_end  = (state == DRAIN) && (dcnt == DW'(MM_LAT - 1));

   assign mat_valid = (state == ISSUE) && !reset;
   assign job_done  = drain_end && !reset;
   assign matrix_1  = m1;
   assign matrix_2  = m2;
   assign err_last  = err_q;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) state <= LOAD_A;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD_A, LOAD_B: begin
            if (accept) begin
               if (early_last) begin
`ifdef MAT_FEEDER_PAD_EN
                  state_nxt = ISSUE;
`else
                  state_nxt = LOAD_A;
`endif
               end else if (k_end) begin
                  state_nxt = (state == LOAD_A) ? LOAD_B : ISSUE;
               end
            end
         end
         ISSUE:   state_nxt = last_pend ? DRAIN : LOAD_A;
         DRAIN:   if (drain_end) state_nxt = LOAD_A;
         default: state_nxt = LOAD_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k         <= '0;
         dcnt      <= '0;
         last_pend <= 1'b0;
         err_q     <= 1'b0;
         m1        <= '0;
         m2        <= '0;
      end else begin
         case (state)
            LOAD_A, LOAD_B: begin
               if (accept) begin
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        if (k == KW'(r * N + c)) begin
                           if (state == LOAD_A) m1[r][c] <= s_data;
                           else                 m2[r][c] <= s_data;
                        end
                     end
                  end
                  if (early_last) begin
                     k <= '0;
`ifdef MAT_FEEDER_PAD_EN
                     last_pend <= 1'b1;
`else
                     // Partial pair is dropped; the clear overrides the element write above.
                     err_q <= 1'b1;
                     m1    <= '0;
                     m2    <= '0;
`endif
                  end else if (k_end) begin
                     k <= '0;
                     if (state == LOAD_B) last_pend <= s_last;
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end
            ISSUE: begin
               m1        <= '0;
               m2        <= '0;
               last_pend <= 1'b0;
               dcnt      <= '0;
            end
            DRAIN:   dcnt <= dcnt + DW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_feeder.sv
// Self-checking bench for mat_feeder: directed scenarios plus randomized jobs
// checked against a pair-level reference model of the element stream.
module tb_mat_feeder;
   import mat_pkg::*;

   localparam int W_IN   = 8;
   localparam int N      = 2;
   localparam int NN     = N * N;
   localparam int PW     = 2 * NN * W_IN;
   localparam int MM_LAT = mm_latency(N);
`ifdef MAT_FEEDER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic s_valid = 1'b0;
   logic s_ready;
   logic signed [W_IN-1:0] s_data = '0;
   logic s_last = 1'b0;
   logic mat_valid;
   logic [N-1:0][N-1:0][W_IN-1:0] matrix_1, matrix_2;
   logic job_done;
   logic err_last;
   feeder_state_t dbg_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   mat_feeder #(.W_IN(W_IN), .N(N)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .mat_valid(mat_valid),
      .matrix_1(matrix_1), .matrix_2(matrix_2), .job_done(job_done),
      .err_last(err_last), .dbg_state(dbg_state)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor and reference model ----------------
   logic [PW-1:0] obs_q[$];
   int            obs_vcyc_q[$];
   int            obs_done_q[$];
   logic [PW-1:0] exp_q[$];
   int            exp_vcyc_q[$];
   int            exp_done_q[$];
   logic          exp_err = 1'b0;
   int            rdy_low = 0;
   logic [W_IN-1:0] m_a[NN];
   logic [W_IN-1:0] m_b[NN];
   int            mcnt = 0;

   function automatic logic [PW-1:0] pack_pair(input logic [W_IN-1:0] a[NN], input logic [W_IN-1:0] b[NN]);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < NN; i++) begin
         p[PW/2 + i*W_IN +: W_IN] = a[i];
         p[i*W_IN +: W_IN]        = b[i];
      end
      return p;
   endfunction

   always @(negedge clk) begin
      if (mat_valid) begin
         obs_q.push_back({matrix_1, matrix_2});
         obs_vcyc_q.push_back(cyc);
      end
      if (job_done) obs_done_q.push_back(cyc);
      if (!reset && !s_ready) rdy_low++;
      if (reset) begin
         // A reset edge discards any pulse still due from now on.
         for (int i = exp_vcyc_q.size() - 1; i >= 0; i--)
            if (exp_vcyc_q[i] >= cyc) begin exp_q.delete(i); exp_vcyc_q.delete(i); end
         for (int i = exp_done_q.size() - 1; i >= 0; i--)
            if (exp_done_q[i] >= cyc) exp_done_q.delete(i);
         mcnt = 0;
         exp_err = 1'b0;
         for (int i = 0; i < NN; i++) begin m_a[i] = '0; m_b[i] = '0; end
      end else if (s_valid && s_ready) begin
         if (mcnt < NN) m_a[mcnt] = s_data;
         else           m_b[mcnt-NN] = s_data;
         mcnt++;
         if (mcnt == 2*NN || s_last) begin
            if (mcnt == 2*NN || PAD) begin
               exp_q.push_back(pack_pair(m_a, m_b));
               exp_vcyc_q.push_back(cyc + 1);
               if (s_last) exp_done_q.push_back(cyc + 1 + MM_LAT);
            end else begin
               exp_err = 1'b1;
            end
            mcnt = 0;
            for (int i = 0; i < NN; i++) begin m_a[i] = '0; m_b[i] = '0; end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      obs_q.delete(); obs_vcyc_q.delete(); obs_done_q.delete();
      exp_q.delete(); exp_vcyc_q.delete(); exp_done_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
   endtask

   // Presents one beat and returns the cycle index that follows its accepting edge.
   task automatic send(input logic [W_IN-1:0] d, input logic l, input int gap_max, output int acc);
      int t;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = d; s_last = l;
      t = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 50) begin
            failures++;
            $display("FAIL send_timeout: s_ready stayed %0b for %0d cycles, required 1", s_ready, t);
            break;
         end
      end
      @(posedge clk); #1;
      acc = cyc;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_seq_1_8(input logic last, output int acc);
      for (int i = 1; i <= 2*NN; i++) send(W_IN'(i), last && (i == 2*NN), 0, acc);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %0b want 0", s_ready); end
      checks++; if (mat_valid !== 1'b0) begin failures++; $display("FAIL reset_mat_valid: got %0b want 0", mat_valid); end
      checks++; if (job_done !== 1'b0) begin failures++; $display("FAIL reset_job_done: got %0b want 0", job_done); end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready: got %0b want 1", s_ready); end
      checks++; if ({matrix_1, matrix_2} !== '0) begin failures++; $display("FAIL post_reset_matrices: got %h want 0", {matrix_1, matrix_2}); end
      checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL post_reset_err_last: got %0b want 0", err_last); end
      checks++; if (dbg_state !== LOAD_A) begin failures++; $display("FAIL post_reset_state: got %0d want %0d", dbg_state, LOAD_A); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_pair();
      int acc;
      clear_logs();
      send_seq_1_8(1'b1, acc);
      idle(6);
      checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         checks++; if (obs_q[0] !== 64'h04030201_08070605) begin failures++; $display("FAIL single_pair_data: got %h want 0403020108070605", obs_q[0]); end
         checks++; if (obs_vcyc_q[0] !== acc) begin failures++; $display("FAIL single_issue_cycle: got %0d want %0d", obs_vcyc_q[0], acc); end
      end
      checks++; if (obs_done_q.size() !== 1) begin failures++; $display("FAIL single_done_count: got %0d want 1", obs_done_q.size()); end
      else begin
         checks++; if (obs_done_q[0] !== acc + MM_LAT) begin failures++; $display("FAIL single_done_cycle: got %0d want %0d", obs_done_q[0], acc + MM_LAT); end
      end
   endtask

   task automatic test_two_pair_job();
      int acc;
      clear_logs();
      send_seq_1_8(1'b0, acc);
      send_seq_1_8(1'b1, acc);
      idle(6);
      checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL two_pair_pulses: got %0d want 2", obs_q.size()); end
      else begin
         checks++; if (obs_vcyc_q[1] - obs_vcyc_q[0] !== 2*NN + 1) begin failures++; $display("FAIL two_pair_spacing: got %0d want %0d", obs_vcyc_q[1] - obs_vcyc_q[0], 2*NN + 1); end
         checks++; if (obs_q[0] !== 64'h04030201_08070605 || obs_q[1] !== 64'h04030201_08070605) begin
            failures++; $display("FAIL two_pair_data: got %h %h want 0403020108070605 twice", obs_q[0], obs_q[1]); end
      end
      checks++; if (obs_done_q.size() !== 1) begin failures++; $display("FAIL two_pair_done_count: got %0d want 1", obs_done_q.size()); end
      else begin
         checks++; if (obs_done_q[0] !== acc + MM_LAT) begin failures++; $display("FAIL two_pair_done_cycle: got %0d want %0d", obs_done_q[0], acc + MM_LAT); end
      end
   endtask

   task automatic test_signed_stall();
      int acc, rdy0, npairs;
      logic [W_IN-1:0] pool[4];
      pool[0] = 8'h80; pool[1] = 8'h7f; pool[2] = 8'hff; pool[3] = 8'h01;
      clear_logs();
      rdy0 = rdy_low;
      for (int job = 0; job < 5; job++) begin
         npairs = $urandom_range(1, 3);
         for (int p = 0; p < npairs; p++)
            for (int e = 0; e < 2*NN; e++)
               send(($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : W_IN'($urandom),
                    (p == npairs - 1) && (e == 2*NN - 1), 2, acc);
      end
      idle(8);
      checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_pair[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
            checks++; if (obs_vcyc_q[i] !== exp_vcyc_q[i]) begin failures++; $display("FAIL rand_issue_cycle[%0d]: got %0d want %0d", i, obs_vcyc_q[i], exp_vcyc_q[i]); end
         end
      end
      checks++; if (obs_done_q !== exp_done_q) begin failures++; $display("FAIL rand_done_cycles: got %0d pulses want %0d", obs_done_q.size(), exp_done_q.size()); end
      checks++; if (rdy_low - rdy0 !== exp_q.size() + MM_LAT * exp_done_q.size()) begin
         failures++; $display("FAIL rand_ready_low_cycles: got %0d want %0d", rdy_low - rdy0, exp_q.size() + MM_LAT * exp_done_q.size()); end
   endtask

   task automatic test_early_last();
      int acc;
      clear_logs();
      send(8'd1, 1'b0, 0, acc);
      send(8'd2, 1'b1, 0, acc);
      idle(6);
      if (PAD) begin
         checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL pad_pulses: got %0d want 1", obs_q.size()); end
         else begin
            checks++; if (obs_q[0] !== 64'h00000201_00000000) begin failures++; $display("FAIL pad_pair_data: got %h want 0000020100000000", obs_q[0]); end
            checks++; if (obs_vcyc_q[0] !== acc) begin failures++; $display("FAIL pad_issue_cycle: got %0d want %0d", obs_vcyc_q[0], acc); end
         end
         checks++; if (obs_done_q.size() !== 1) begin failures++; $display("FAIL pad_done_count: got %0d want 1", obs_done_q.size()); end
         checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL pad_err_last: got %0b want 0", err_last); end
      end else begin
         checks++; if (obs_q.size() !== 0 || obs_done_q.size() !== 0) begin
            failures++; $display("FAIL nopad_no_pulses: got %0d issues %0d dones want 0 0", obs_q.size(), obs_done_q.size()); end
         checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL nopad_err_last: got %0b want 1", err_last); end
         send_seq_1_8(1'b1, acc);
         idle(6);
         checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL nopad_recover_pulses: got %0d want 1", obs_q.size()); end
         else begin
            checks++; if (obs_q[0] !== 64'h04030201_08070605) begin failures++; $display("FAIL nopad_recover_data: got %h want 0403020108070605", obs_q[0]); end
         end
         checks++; if (obs_done_q.size() !== 1) begin failures++; $display("FAIL nopad_recover_done: got %0d want 1", obs_done_q.size()); end
         checks++; if (err_last !== 1'b1) begin failures++; $display("FAIL nopad_err_sticky: got %0b want 1", err_last); end
      end
      checks++; if (err_last !== exp_err) begin failures++; $display("FAIL early_err_model: got %0b want %0b", err_last, exp_err); end
      pulse_reset();
      @(negedge clk);
      checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL err_cleared_by_reset: got %0b want 0", err_last); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_drain();
      int acc;
      clear_logs();
      send_seq_1_8(1'b1, acc);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL drain_reset_s_ready: got %0b want 1", s_ready); end
      checks++; if ({mat_valid, job_done, err_last} !== 3'b000) begin failures++; $display("FAIL drain_reset_flags: got %b want 000", {mat_valid, job_done, err_last}); end
      checks++; if ({matrix_1, matrix_2} !== '0) begin failures++; $display("FAIL drain_reset_matrices: got %h want 0", {matrix_1, matrix_2}); end
      idle(6);
      checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL drain_reset_issues: got %0d want 1", obs_q.size()); end
      checks++; if (obs_done_q.size() !== 0 || exp_done_q.size() !== 0) begin
         failures++; $display("FAIL drain_reset_no_done: got %0d dones want 0", obs_done_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_pair();
      test_two_pair_job();
      test_signed_stall();
      test_early_last();
      test_reset_in_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
      $fatal(1, "timeout");
   end

endmodule
